// File: rtl/nonce_sweeper_pkg.sv
// Shared definitions for the nonce sweeper: job field widths, the job and
// hash-request payloads, and the sweep state encoding.
package nonce_sweeper_pkg;

  localparam int unsigned MIDSTATE_W    = 256;
  localparam int unsigned DATA_W        = 96;
  localparam int unsigned NONCE_W       = 32;
  localparam int unsigned HASH_W        = 256;
  localparam int unsigned DEFAULT_TAG_W = 2;
  localparam int unsigned DROP_W        = 8;
  localparam int unsigned JOB_SIZE      = MIDSTATE_W + DATA_W + 2 * NONCE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sweep_state_e;

  // Job as delivered by the UART receiver.
  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
    logic [NONCE_W-1:0]    nonce_min;
    logic [NONCE_W-1:0]    nonce_max;
  } job_t;

  // Constant part of every hasher request for one job.
  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
  } hash_req_t;

  // An inverted range means there is nothing to issue.
  function automatic logic range_empty(input logic [NONCE_W-1:0] lo,
                                       input logic [NONCE_W-1:0] hi);
    return lo > hi;
  endfunction

endpackage

// File: rtl/nonce_sweeper_golden_reporter.sv
// Golden nonce reporter: one-entry pending slot, hold-off counter between
// reports, toggle-style report flag and saturating drop counter.
// Ports:
//   hash_clk, reset          clock, async active-high reset
//   golden, golden_in        qualified winning result and its nonce
//   golden_nonce             last reported nonce, stable between toggles
//   new_golden_nonce         toggles once per reported nonce
//   drop_count               winners lost because the slot was full
module nonce_sweeper_golden_reporter
  import nonce_sweeper_pkg::*;
#(
  parameter int unsigned GOLDEN_HOLD = 64
) (
  input  logic               hash_clk,
  input  logic               reset,
  input  logic               golden,
  input  logic [NONCE_W-1:0] golden_in,
  output logic [NONCE_W-1:0] golden_nonce,
  output logic               new_golden_nonce,
  output logic [DROP_W-1:0]  drop_count
);

  localparam int unsigned HOLD_W = (GOLDEN_HOLD > 1) ? $clog2(GOLDEN_HOLD) : 1;

  logic               pending_vld;
  logic [NONCE_W-1:0] pending_nonce;
  logic [HOLD_W-1:0]  hold;
  logic               report_c;
  logic               slot_free_c;

  assign report_c    = pending_vld && (hold == '0);
  // The slot may be emptied by a report and refilled in the same cycle.
  assign slot_free_c = !pending_vld || report_c;

  // Report pending nonce once the hold-off window has expired.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      golden_nonce     <= '0;
      new_golden_nonce <= 1'b0;
      hold             <= '0;
    end else if (report_c) begin
      golden_nonce     <= pending_nonce;
      new_golden_nonce <= ~new_golden_nonce;
      hold             <= HOLD_W'(GOLDEN_HOLD - 1);
    end else if (hold != '0) begin
      hold <= hold - HOLD_W'(1);
    end
  end

  // Pending slot fill/empty.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      pending_vld   <= 1'b0;
      pending_nonce <= '0;
    end else if (golden && slot_free_c) begin
      pending_vld   <= 1'b1;
      pending_nonce <= golden_in;
    end else if (report_c) begin
      pending_vld <= 1'b0;
    end
  end

  // Saturating count of winners that found the slot occupied.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (golden && !slot_free_c && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: rtl/nonce_sweeper.sv
// Nonce sweeper: walks [nonce_min, nonce_max] into a pipelined SHA-256d
// hasher, filters returned hashes against a leading-zero difficulty and
// hands winners to the golden reporter.
// Ports:
//   hash_clk, reset                       clock, async active-high reset
//   new_work, midstate, work_data,
//   nonce_min, nonce_max                  job from the receiver
//   hash_ready, hash_start, hash_midstate,
//   hash_data, hash_nonce, hash_tag       request channel to the hasher
//   result_valid, result_hash,
//   result_nonce, result_tag              result channel from the hasher
//   golden_nonce, new_golden_nonce        winner report to the receiver
//   busy, sweep_done, drop_count          status
module nonce_sweeper
  import nonce_sweeper_pkg::*;
#(
  parameter int unsigned ZERO_BITS   = 32,
  parameter int unsigned TAG_W       = DEFAULT_TAG_W,
  parameter int unsigned INFLIGHT_W  = 8,
  parameter int unsigned GOLDEN_HOLD = 64
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  new_work,
  input  logic [MIDSTATE_W-1:0] midstate,
  input  logic [DATA_W-1:0]     work_data,
  input  logic [NONCE_W-1:0]    nonce_min,
  input  logic [NONCE_W-1:0]    nonce_max,
  input  logic                  hash_ready,
  output logic                  hash_start,
  output logic [MIDSTATE_W-1:0] hash_midstate,
  output logic [DATA_W-1:0]     hash_data,
  output logic [NONCE_W-1:0]    hash_nonce,
  output logic [TAG_W-1:0]      hash_tag,
  input  logic                  result_valid,
  input  logic [HASH_W-1:0]     result_hash,
  input  logic [NONCE_W-1:0]    result_nonce,
  input  logic [TAG_W-1:0]      result_tag,
  output logic [NONCE_W-1:0]    golden_nonce,
  output logic                  new_golden_nonce,
  output logic                  busy,
  output logic                  sweep_done,
  output logic [DROP_W-1:0]     drop_count
);

  sweep_state_e          state_q, state_d;
  logic [JOB_SIZE-1:0]   job_flat_c;
  job_t                  job_c;
  hash_req_t             req_q;
  logic [NONCE_W-1:0]    nonce_max_q;
  logic [NONCE_W-1:0]    cur_q;
  logic [TAG_W-1:0]      tag_q;
  logic [INFLIGHT_W-1:0] inflight_q;
  logic                  transfer_c;
  logic                  last_c;
  logic                  golden_c;

  assign job_flat_c = {midstate, work_data, nonce_min, nonce_max};
  assign job_c      = job_t'(job_flat_c);

  assign hash_start    = (state_q == ST_SWEEP);
  assign transfer_c    = hash_start && hash_ready;
  assign last_c        = (cur_q == nonce_max_q);
  assign hash_midstate = req_q.midstate;
  assign hash_data     = req_q.data;
  assign hash_nonce    = cur_q;
  assign hash_tag      = tag_q;
  assign busy          = (state_q != ST_IDLE);
  assign sweep_done    = (state_q == ST_DRAIN) && (inflight_q == '0);

  // State register.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a new job overrides whatever the sweep was doing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_SWEEP: if (transfer_c && last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (new_work) begin
      state_d = range_empty(job_c.nonce_min, job_c.nonce_max) ? ST_DRAIN : ST_SWEEP;
    end
  end

  // Job latch, tag and nonce cursor. The cursor stops at nonce_max so an
  // all-ones upper bound never wraps back to zero.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      nonce_max_q <= '0;
      cur_q       <= '0;
      tag_q       <= '0;
    end else if (new_work) begin
      req_q.midstate <= job_c.midstate;
      req_q.data     <= job_c.data;
      nonce_max_q    <= job_c.nonce_max;
      cur_q          <= job_c.nonce_min;
      tag_q          <= tag_q + TAG_W'(1);
    end else if (transfer_c && !last_c) begin
      cur_q <= cur_q + NONCE_W'(1);
    end
  end

  // Outstanding requests, including ones from superseded jobs. Clamped at
  // zero so results still in the hasher after a reset are harmless.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      unique case ({transfer_c, result_valid})
        2'b10:   inflight_q <= inflight_q + INFLIGHT_W'(1);
        2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - INFLIGHT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Winner: current-job tag (pre-update on a coinciding new_work) and
  // enough leading zero bits. Results arriving while idle are stale.
  assign golden_c = result_valid && (state_q != ST_IDLE) && (result_tag == tag_q) &&
                    (result_hash[HASH_W-1 -: ZERO_BITS] == '0);

  generate
    if (ZERO_BITS < HASH_W) begin : g_low_hash
      logic unused_low_hash;
      assign unused_low_hash = ^result_hash[HASH_W-ZERO_BITS-1:0];
    end
  endgenerate

  nonce_sweeper_golden_reporter #(
    .GOLDEN_HOLD(GOLDEN_HOLD)
  ) u_reporter (
    .hash_clk        (hash_clk),
    .reset           (reset),
    .golden          (golden_c),
    .golden_in       (result_nonce),
    .golden_nonce    (golden_nonce),
    .new_golden_nonce(new_golden_nonce),
    .drop_count      (drop_count)
  );

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench for nonce_sweeper with a depth-4 hasher model.
module tb_nonce_sweeper;

  logic          hash_clk;
  logic          reset;
  logic          new_work;
  logic [255:0]  midstate;
  logic [95:0]   work_data;
  logic [31:0]   nonce_min;
  logic [31:0]   nonce_max;
  logic          hash_ready;
  logic          hash_start;
  logic [255:0]  hash_midstate;
  logic [95:0]   hash_data;
  logic [31:0]   hash_nonce;
  logic [1:0]    hash_tag;
  logic          result_valid;
  logic [255:0]  result_hash;
  logic [31:0]   result_nonce;
  logic [1:0]    result_tag;
  logic [31:0]   golden_nonce;
  logic          new_golden_nonce;
  logic          busy;
  logic          sweep_done;
  logic [7:0]    drop_count;

  nonce_sweeper #(
    .ZERO_BITS(32), .TAG_W(2), .INFLIGHT_W(8), .GOLDEN_HOLD(64)
  ) dut (
    .hash_clk(hash_clk), .reset(reset), .new_work(new_work),
    .midstate(midstate), .work_data(work_data),
    .nonce_min(nonce_min), .nonce_max(nonce_max),
    .hash_ready(hash_ready), .hash_start(hash_start),
    .hash_midstate(hash_midstate), .hash_data(hash_data),
    .hash_nonce(hash_nonce), .hash_tag(hash_tag),
    .result_valid(result_valid), .result_hash(result_hash),
    .result_nonce(result_nonce), .result_tag(result_tag),
    .golden_nonce(golden_nonce), .new_golden_nonce(new_golden_nonce),
    .busy(busy), .sweep_done(sweep_done), .drop_count(drop_count)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  // Hasher model: fixed 4-stage pipeline, zero hash for chosen nonces.
  typedef struct packed {
    logic        v;
    logic        z;
    logic [31:0] n;
    logic [1:0]  t;
  } stg_t;

  stg_t        pipe [0:3];
  logic        pipe_clr;
  logic [31:0] gold [0:3];
  int          gold_n;
  logic [31:0] issued [$];

  function automatic logic is_gold(input logic [31:0] n);
    for (int i = 0; i < gold_n; i++) if (gold[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge hash_clk) begin
    if (pipe_clr) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: hash_start && hash_ready, z: is_gold(hash_nonce), n: hash_nonce, t: hash_tag};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (hash_start && hash_ready) issued.push_back(hash_nonce);
    end
  end

  assign result_valid = pipe[3].v;
  assign result_nonce = pipe[3].n;
  assign result_tag   = pipe[3].t;
  assign result_hash  = pipe[3].z ? '0 : '1;

  // Per-cycle log, index 0 = negedge right after new_work was sampled.
  localparam int LOGN = 128;
  int          cyc;
  logic        busy_log [0:LOGN-1];
  logic        done_log [0:LOGN-1];
  logic        ng_log   [0:LOGN-1];
  logic [31:0] gn_log   [0:LOGN-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic log_now();
    if (cyc < LOGN) begin
      busy_log[cyc] = busy;
      done_log[cyc] = sweep_done;
      ng_log[cyc]   = new_golden_nonce;
      gn_log[cyc]   = golden_nonce;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge hash_clk);
      cyc++;
      log_now();
    end
  endtask

  task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
    new_work  = 1'b1;
    nonce_min = lo;
    nonce_max = hi;
    @(negedge hash_clk);
    new_work = 1'b0;
    cyc = 0;
    log_now();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (6) @(negedge hash_clk);
    reset = 1'b0;
    issued.delete();
  endtask

  function automatic int count_done(input int hi);
    int c = 0;
    for (int i = 0; i <= hi; i++) if (done_log[i]) c++;
    return c;
  endfunction

  function automatic int count_toggles(input int hi);
    int c = 0;
    for (int i = 1; i <= hi; i++) if (ng_log[i] != ng_log[i-1]) c++;
    return c;
  endfunction

  function automatic int toggle_at(input int k, input int hi);
    int c = 0;
    for (int i = 1; i <= hi; i++) begin
      if (ng_log[i] != ng_log[i-1]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  initial begin
    pipe_clr   = 1'b1;
    reset      = 1'b1;
    new_work   = 1'b0;
    midstate   = {8{32'hA5C3_0F1E}};
    work_data  = {3{32'h1234_5678}};
    nonce_min  = '0;
    nonce_max  = '0;
    hash_ready = 1'b1;
    gold_n     = 0;
    cyc        = 0;
    repeat (3) @(negedge hash_clk);
    chk("rst_busy",   64'(busy), 64'h0);
    chk("rst_start",  64'(hash_start), 64'h0);
    chk("rst_ng",     64'(new_golden_nonce), 64'h0);
    chk("rst_gn",     64'(golden_nonce), 64'h0);
    chk("rst_drop",   64'(drop_count), 64'h0);
    chk("rst_done",   64'(sweep_done), 64'h0);
    pipe_clr = 1'b0;
    do_reset();

    // Basic sweep 0x10..0x13, 0x12 wins.
    gold[0] = 32'h12; gold_n = 1;
    start_job(32'h10, 32'h13);
    chk("t1_start", 64'(hash_start), 64'h1);
    chk("t1_nonce0", 64'(hash_nonce), 64'h10);
    chk("t1_tag", 64'(hash_tag), 64'h1);
    chk("t1_midstate", 64'(hash_midstate == {8{32'hA5C3_0F1E}}), 64'h1);
    chk("t1_data", 64'(hash_data == {3{32'h1234_5678}}), 64'h1);
    step(15);
    chk("t1_n_issued", 64'(issued.size()), 64'h4);
    for (int k = 0; k < 4 && k < issued.size(); k++) chk("t1_issued", 64'(issued[k]), 64'(32'h10 + k));
    chk("t1_busy8", 64'(busy_log[8]), 64'h1);
    chk("t1_busy9", 64'(busy_log[9]), 64'h0);
    chk("t1_done8", 64'(done_log[8]), 64'h1);
    chk("t1_done_n", 64'(count_done(15)), 64'h1);
    chk("t1_ng7", 64'(ng_log[7]), 64'h0);
    chk("t1_tog_at", 64'(toggle_at(0, 15)), 64'h8);
    chk("t1_gn8", 64'(gn_log[8]), 64'h12);
    do_reset();

    // Top-of-range sweep must not wrap.
    gold_n = 0;
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    step(12);
    chk("t2_n_issued", 64'(issued.size()), 64'h2);
    if (issued.size() == 2) begin
      chk("t2_issued0", 64'(issued[0]), 64'hFFFF_FFFE);
      chk("t2_issued1", 64'(issued[1]), 64'hFFFF_FFFF);
    end
    chk("t2_done6", 64'(done_log[6]), 64'h1);
    chk("t2_done_n", 64'(count_done(12)), 64'h1);
    chk("t2_busy7", 64'(busy_log[7]), 64'h0);
    do_reset();

    // Three back-to-back winners: report, hold, drop.
    gold[0] = 32'h20; gold[1] = 32'h21; gold[2] = 32'h22; gold_n = 3;
    start_job(32'h20, 32'h22);
    step(80);
    chk("t4_toggles", 64'(count_toggles(80)), 64'h2);
    chk("t4_tog0", 64'(toggle_at(0, 80)), 64'h6);
    chk("t4_gn6", 64'(gn_log[6]), 64'h20);
    chk("t4_tog1", 64'(toggle_at(1, 80)), 64'd70);
    chk("t4_gn69", 64'(gn_log[69]), 64'h20);
    chk("t4_gn70", 64'(gn_log[70]), 64'h21);
    chk("t4_drop", 64'(drop_count), 64'h1);
    do_reset();

    // New job mid-sweep: tag-1 winners ignored, drain covers both jobs.
    gold[0] = 32'h40; gold[1] = 32'h41; gold[2] = 32'h81; gold_n = 3;
    start_job(32'h40, 32'h4F);
    step(2);
    new_work  = 1'b1;
    nonce_min = 32'h80;
    nonce_max = 32'h81;
    step(1);
    new_work = 1'b0;
    chk("t5_tag", 64'(hash_tag), 64'h2);
    chk("t5_restart", 64'(hash_nonce), 64'h80);
    step(15);
    chk("t5_n_issued", 64'(issued.size()), 64'h5);
    if (issued.size() == 5) begin
      chk("t5_issued2", 64'(issued[2]), 64'h42);
      chk("t5_issued3", 64'(issued[3]), 64'h80);
      chk("t5_issued4", 64'(issued[4]), 64'h81);
    end
    chk("t5_done9", 64'(done_log[9]), 64'h1);
    chk("t5_done_n", 64'(count_done(18)), 64'h1);
    chk("t5_busy10", 64'(busy_log[10]), 64'h0);
    chk("t5_toggles", 64'(count_toggles(18)), 64'h1);
    chk("t5_tog_at", 64'(toggle_at(0, 18)), 64'd10);
    chk("t5_gn", 64'(golden_nonce), 64'h81);
    do_reset();

    // Backpressure: hash_ready alternating.
    gold[0] = 32'h61; gold_n = 1;
    start_job(32'h60, 32'h63);
    for (int k = 0; k < 20; k++) begin
      hash_ready = ~hash_ready;
      step(1);
    end
    hash_ready = 1'b1;
    step(12);
    chk("t6_n_issued", 64'(issued.size()), 64'h4);
    for (int k = 0; k < 4 && k < issued.size(); k++) chk("t6_issued", 64'(issued[k]), 64'(32'h60 + k));
    chk("t6_gn", 64'(golden_nonce), 64'h61);
    chk("t6_ng", 64'(new_golden_nonce), 64'h1);

    // Asynchronous reset in the middle of a sweep.
    gold_n = 0;
    start_job(32'h100, 32'h1FF);
    step(3);
    chk("t7_busy_pre", 64'(busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t7_busy", 64'(busy), 64'h0);
    chk("t7_start", 64'(hash_start), 64'h0);
    chk("t7_nonce", 64'(hash_nonce), 64'h0);
    chk("t7_tag", 64'(hash_tag), 64'h0);
    chk("t7_ng", 64'(new_golden_nonce), 64'h0);
    chk("t7_gn", 64'(golden_nonce), 64'h0);
    @(negedge hash_clk);
    @(negedge hash_clk);
    reset = 1'b0;
    repeat (8) @(negedge hash_clk);
    chk("t7_busy_post", 64'(busy), 64'h0);
    chk("t7_done_post", 64'(sweep_done), 64'h0);
    issued.delete();
    // Stale results above must not have left the in-flight count wrapped.
    start_job(32'h5, 32'h5);
    step(10);
    chk("t7_n_issued", 64'(issued.size()), 64'h1);
    chk("t7_done5", 64'(done_log[5]), 64'h1);
    chk("t7_busy6", 64'(busy_log[6]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
